ring_phase_sequencer: RTL and testbench
=======================================

# ring_phase_sequencer

Parametrised one-hot ring sequencer that generates N mutually exclusive phase enables for multi-phase datapaths. It supersedes the fixed 9-stage ring counter and adds:
- step enable and direction control
- one-shot mode with halt/restart
- synchronous load and clear
- encoded phase index and a wrap pulse
- automatic recovery from corrupted (non-one-hot) state, with a sticky error flag

It sits between the top-level control FSM and the per-phase datapath enables.

## Interface
- N, 9, number of phases; legal 2..32
- IDX_W, 4, index width; must satisfy 2**IDX_W >= N
- START, 0, phase index entered on reset/sync_clr; must be < N

- clk  in  1  clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- en  in  1  step enable; phase advances one position per cycle while high and running
- dir  in  1  0 = forward (i → i+1), 1 = reverse (i → i−1)
- oneshot  in  1  1 = halt on reaching the terminal phase
- start  in  1  restarts a halted sequencer (level sampled each edge)
- sync_clr  in  1  synchronous return to START
- load  in  1  synchronous jump to load_idx
- load_idx  in  IDX_W  target phase for load
- phase  out  N  one-hot registered phase vector
- strb  out  N  phase & {N{clk}}; high-phase-of-clock gated strobes
- idx  out  IDX_W  binary index of phase
- wrap  out  1  registered one-cycle pulse on ring wrap
- done  out  1  1 while halted
- err  out  1  sticky integrity/load error

## Operation
- State: phase[N-1:0], run (RUN/HALT), wrap, err.
- Reset values:
  - phase = one-hot(START)
  - run = RUN; done = 0
  - wrap = 0; err = 0
  - idx = START; strb = 0 while clk low
- Per-edge priority, highest first:
  1. sync_clr: phase = one-hot(START), run = RUN, err = 0, wrap = 0.
  2. load:
     - load_idx < N: phase = one-hot(load_idx), wrap = 0; run unchanged.
     - load_idx ≥ N: phase unchanged, err = 1, wrap = 0.
  3. Integrity: if popcount(phase) ≠ 1, phase = one-hot(START), err = 1, wrap = 0; not an advance.
  4. start while HALT: run = RUN; no advance this edge; wrap = 0.
  5. Advance when en=1 and run=RUN:
     - forward: rotate left; reverse: rotate right.
     - wrap = 1 when the move is N−1→0 (forward) or 0→N−1 (reverse); else 0.
     - If oneshot=1 and the new phase is terminal, run = HALT on the same edge. Terminal = N−1 forward, 0 reverse.
  6. Otherwise: hold phase; wrap = 0.
- Halt entry is only by advance. Loading onto the terminal phase does not halt.
- In HALT, en is ignored. A restart's first advance leaves the terminal phase (wrap fires if it crosses the ring end).
- oneshot and dir may change any cycle; they are sampled at the advance edge only.
- done = (run == HALT), combinational from the register.
- idx = index of the lowest set bit of phase; 0 if phase is all-zero.
- err clears only on reset or sync_clr.

## Timing
- Latency: control inputs to phase/idx/wrap/done is one clk edge. No combinational path from inputs to outputs, except clk → strb.
- wrap is high for exactly the one cycle following the wrapping edge.
- strb[i] = phase[i] AND clk. Downstream uses strb only as an enable, never as a clock.
- Asynchronous reset asserts immediately regardless of clk. Deassertion must be synchronised externally.
- Reset mid-sequence: all outputs return to reset values within the assertion; the first post-reset edge acts normally.
- Simultaneous events resolve strictly by the priority list:
  - sync_clr + load: clear wins.
  - load + en: load wins, no advance.
  - start + en in HALT: restart only.

## Test plan
- Reset, N=9, START=0: phase=9'h001, idx=0, done=0, err=0, wrap=0. After 9 edges with en=1, dir=0: phase back at 9'h001, wrap high for exactly one cycle (after the 9th edge).
- Reverse with en toggling, N=9: from idx 2 with dir=1, 3 enabled edges give idx 1, 0, 8. wrap pulses after the 0→8 edge. Edges with en=0 hold idx.
- One-shot, N=9, oneshot=1, from idx 0 forward:
  - halts at idx 8 with done=1; further en has no effect.
  - start gives done=0 with idx still 8; the next en edge gives idx 0 and wrap=1.
- Load: load_idx=5 gives phase=9'h020, idx=5. load_idx=12 leaves phase unchanged and sets err=1. sync_clr then gives idx=0, err=0.
- Corruption: force phase=9'h011 for one cycle, then release. The next edge gives phase=9'h001, err=1, wrap=0, no advance.
- Reset mid-run at idx 6 while halted or running: immediately idx=0, done=0, err=0, wrap=0.

Source files
------------

// File: rtl/ring_phase_sequencer.sv
// One-hot ring sequencer producing N mutually exclusive phase enables, with
// step/direction control, one-shot halt/restart, load/clear and self-recovery.
module ring_phase_sequencer #(
   parameter int N     = 9,
   parameter int IDX_W = 4,
   parameter int START = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             dir,
   input  logic             oneshot,
   input  logic             start,
   input  logic             sync_clr,
   input  logic             load,
   input  logic [IDX_W-1:0] load_idx,
   output logic [N-1:0]     phase,
   output logic [N-1:0]     strb,
   output logic [IDX_W-1:0] idx,
   output logic             wrap,
   output logic             done,
   output logic             err
);

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} run_t;

   logic [N-1:0] phase_p0;
   run_t         run_p0;
   logic         wrap_p0;
   logic         err_p0;

   function automatic logic [N-1:0] onehot(input int unsigned i);
      logic [N-1:0] r;
      r = '0;
      r[i] = 1'b1;
      return r;
   endfunction

   function automatic logic is_onehot(input logic [N-1:0] v);
      int c;
      c = 0;
      for (int i = 0; i < N; i++) c += int'(v[i]);
      return (c == 1);
   endfunction

   // Lowest set bit wins, so scan from the top down and let lower bits overwrite.
   function automatic logic [IDX_W-1:0] low_idx(input logic [N-1:0] v);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = N - 1; i >= 0; i--)
         if (v[i]) r = IDX_W'(i);
      return r;
   endfunction

   // Stage p0: single register stage holding the ring, run state and flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_p0 <= onehot(START);
         run_p0   <= RUN;
         wrap_p0  <= 1'b0;
         err_p0   <= 1'b0;
      end else begin
         wrap_p0 <= 1'b0;
         if (sync_clr) begin
            phase_p0 <= onehot(START);
            run_p0   <= RUN;
            err_p0   <= 1'b0;
         end else if (load) begin
            if (int'(load_idx) < N) phase_p0 <= onehot(int'(load_idx));
            else                    err_p0   <= 1'b1;
         end else if (!is_onehot(phase_p0)) begin
            phase_p0 <= onehot(START);
            err_p0   <= 1'b1;
         end else if (start && run_p0 == HALT) begin
            run_p0 <= RUN;
         end else if (en && run_p0 == RUN) begin
            if (!dir) begin
               phase_p0 <= {phase_p0[N-2:0], phase_p0[N-1]};
               wrap_p0  <= phase_p0[N-1];
               if (oneshot && phase_p0[N-2]) run_p0 <= HALT;
            end else begin
               phase_p0 <= {phase_p0[0], phase_p0[N-1:1]};
               wrap_p0  <= phase_p0[0];
               if (oneshot && phase_p0[1]) run_p0 <= HALT;
            end
         end
      end
   end

   assign phase = phase_p0;
   assign strb  = phase_p0 & {N{clk}};
   assign idx   = low_idx(phase_p0);
   assign wrap  = wrap_p0;
   assign done  = (run_p0 == HALT);
   assign err   = err_p0;

endmodule

// File: tb/tb_ring_phase_sequencer.sv
// Directed bench for ring_phase_sequencer (N=9, START=0) with hand-computed
// expected values for stepping, one-shot, load/clear, recovery and reset.
module tb_ring_phase_sequencer;

   localparam int N     = 9;
   localparam int IDX_W = 4;

   logic             clk = 1'b0;
   logic             reset, en, dir, oneshot, start, sync_clr, load;
   logic [IDX_W-1:0] load_idx;
   logic [N-1:0]     phase, strb;
   logic [IDX_W-1:0] idx;
   logic             wrap, done, err;

   int checks = 0;
   int errors = 0;

   ring_phase_sequencer #(.N(N), .IDX_W(IDX_W), .START(0)) dut (
      .clk(clk), .reset(reset), .en(en), .dir(dir), .oneshot(oneshot),
      .start(start), .sync_clr(sync_clr), .load(load), .load_idx(load_idx),
      .phase(phase), .strb(strb), .idx(idx), .wrap(wrap), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; en = 0; dir = 0; oneshot = 0; start = 0;
      sync_clr = 0; load = 0; load_idx = '0;
      #2;
      chk("rst_phase", 32'(phase), 32'h001);
      chk("rst_idx", 32'(idx), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_wrap", 32'(wrap), 0);
      chk("rst_strb_low", 32'(strb), 0);
      #1 reset = 1'b0;

      // forward full lap
      en = 1; dir = 0;
      for (int k = 1; k <= 9; k++) begin
         step();
         chk($sformatf("fwd_idx%0d", k), 32'(idx), k % 9);
         chk($sformatf("fwd_wrap%0d", k), 32'(wrap), (k == 9) ? 1 : 0);
      end
      chk("fwd_phase_lap", 32'(phase), 32'h001);
      chk("strb_high", 32'(strb), 32'h001);
      en = 0; step();
      chk("hold_idx", 32'(idx), 0);
      chk("hold_wrap", 32'(wrap), 0);

      // reverse with en toggling, from idx 2
      load = 1; load_idx = 2; step(); load = 0;
      chk("rev_start", 32'(idx), 2);
      dir = 1;
      en = 1; step(); chk("rev_a", 32'(idx), 1); chk("rev_a_wrap", 32'(wrap), 0);
      en = 0; step(); chk("rev_hold", 32'(idx), 1);
      en = 1; step(); chk("rev_b", 32'(idx), 0); chk("rev_b_wrap", 32'(wrap), 0);
      step();         chk("rev_c", 32'(idx), 8); chk("rev_c_wrap", 32'(wrap), 1);
      en = 0; step(); chk("rev_post_wrap", 32'(wrap), 0); chk("rev_post_idx", 32'(idx), 8);

      // one-shot forward from 0
      sync_clr = 1; step(); sync_clr = 0;
      chk("os_clr", 32'(idx), 0);
      dir = 0; oneshot = 1; en = 1;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk($sformatf("os_idx%0d", k), 32'(idx), k);
         chk($sformatf("os_done%0d", k), 32'(done), (k == 8) ? 1 : 0);
      end
      step();
      chk("os_halt_idx", 32'(idx), 8);
      chk("os_halt_done", 32'(done), 1);
      start = 1; step(); start = 0;
      chk("os_restart_done", 32'(done), 0);
      chk("os_restart_idx", 32'(idx), 8);
      step();
      chk("os_leave_idx", 32'(idx), 0);
      chk("os_leave_wrap", 32'(wrap), 1);
      chk("os_leave_done", 32'(done), 0);
      oneshot = 0; en = 0;

      // load / error / clear and priority
      load = 1; load_idx = 5; step();
      chk("ld5_phase", 32'(phase), 32'h020);
      chk("ld5_idx", 32'(idx), 5);
      load_idx = 12; step();
      chk("ld12_phase", 32'(phase), 32'h020);
      chk("ld12_err", 32'(err), 1);
      load = 0; sync_clr = 1; step(); sync_clr = 0;
      chk("clr_idx", 32'(idx), 0);
      chk("clr_err", 32'(err), 0);
      sync_clr = 1; load = 1; load_idx = 5; step(); sync_clr = 0;
      chk("clr_beats_load", 32'(idx), 0);
      load_idx = 3; en = 1; step(); load = 0;
      chk("load_beats_en", 32'(idx), 3);

      // corrupted state recovery
      force dut.phase_p0 = 9'h011;
      #1 release dut.phase_p0;
      step();
      chk("corr_phase", 32'(phase), 32'h001);
      chk("corr_err", 32'(err), 1);
      chk("corr_wrap", 32'(wrap), 0);
      step();
      chk("corr_then_adv", 32'(idx), 1);

      // reset mid-run at idx 6 with err set
      sync_clr = 1; step(); sync_clr = 0;
      for (int k = 0; k < 6; k++) step();
      en = 0; load = 1; load_idx = 12; step(); load = 0;
      chk("pre_rst_idx", 32'(idx), 6);
      chk("pre_rst_err", 32'(err), 1);
      reset = 1; #1;
      chk("mid_rst_idx", 32'(idx), 0);
      chk("mid_rst_err", 32'(err), 0);
      chk("mid_rst_done", 32'(done), 0);
      chk("mid_rst_wrap", 32'(wrap), 0);
      #2 reset = 0;

      // reset while halted
      oneshot = 1; en = 1; dir = 0;
      for (int k = 0; k < 8; k++) step();
      chk("pre_rst_halt", 32'(done), 1);
      reset = 1; #1;
      chk("halt_rst_done", 32'(done), 0);
      chk("halt_rst_phase", 32'(phase), 32'h001);
      #2 reset = 0; oneshot = 0;
      step();
      chk("post_rst_adv", 32'(idx), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
